// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encodings and default multiply latency for the hazard controller.
package hazard_pkg;
    localparam int MUL_LAT_DEF = 3;
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_e;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between the EX load and the ID sources.
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [1:0] ex_rd,
    input  logic [1:0] id_rs,
    input  logic [1:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);
    assign load_use = ex_mem_read && ex_reg_write &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/hold control for a 5-stage pipeline with multi-cycle multiply
// and data-memory wait states; also keeps a saturating count of PC stall cycles.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] id_rs,
    input  logic [1:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic       ex_reg_write,
    input  logic [1:0] ex_rd,
    input  logic       ex_is_mul,
    input  logic       branch_taken,
    input  logic       mem_wait,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       id_ex_hold,
    output logic       ex_mem_hold,
    output logic       ex_mem_flush,
    output logic [1:0] ctrl_state,
    output logic [7:0] stall_cycles
);
    state_e     state_q, state_d, saved_q, saved_d, eff_state;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] stall_q, stall_d;
    logic       load_use;

    hazard_detect u_detect (
        .ex_mem_read (ex_mem_read),
        .ex_reg_write(ex_reg_write),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (load_use)
    );

    // Leaving MEM_WAIT, this cycle is decided by the rules of the interrupted state.
    assign eff_state = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        ex_mem_hold  = 1'b0;
        ex_mem_flush = 1'b0;
        state_d      = state_q;
        saved_d      = saved_q;
        cnt_d        = cnt_q;
        if (mem_wait) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_hold  = 1'b1;
            ex_mem_hold = 1'b1;
            state_d     = ST_MEM_WAIT;
            saved_d     = (state_q == ST_MEM_WAIT) ? saved_q : state_q;
        end else begin
            case (eff_state)
                ST_RUN: begin
                    state_d = ST_RUN;
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_is_mul) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_hold   = 1'b1;
                        ex_mem_flush = 1'b1;
                        cnt_d        = 4'(MUL_LAT - 1);
                        state_d      = ST_MUL_BUSY;
                    end else if (load_use) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_MUL_BUSY: begin
                    cnt_d = (cnt_q > 4'd1) ? cnt_q - 4'd1 : 4'd0;
                    if (cnt_q > 4'd1) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_hold   = 1'b1;
                        ex_mem_flush = 1'b1;
                        state_d      = ST_MUL_BUSY;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
        stall_d = (pc_stall && stall_q != 8'hFF) ? stall_q + 8'd1 : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            cnt_q   <= 4'd0;
            stall_q <= 8'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign ctrl_state   = state_q;
    assign stall_cycles = stall_q;
endmodule
